// File: rtl/food_spawner.sv
// Multi-player food manager: head/food hit detection and scoring on each game tick,
// plus an LFSR refill FSM that validates one body segment index per cycle before committing.
module food_spawner #(
  parameter int          num_players = 2,
  parameter int          num_foods   = 2,
  parameter int          max_len     = 16,
  parameter int          num_len     = 10,
  parameter int          score_len   = 4,
  parameter int          width       = 32,
  parameter int          height      = 24,
  parameter logic [15:0] lfsr_seed   = 16'hACE1
) (
  input  logic                                   clk,
  input  logic                                   rst,
  input  logic                                   tick,
  input  logic [num_players*max_len*num_len-1:0] snakes,
  input  logic [num_players*score_len-1:0]       lens,
  input  logic [num_players*num_len-1:0]         heads,
  output logic [num_foods*num_len-1:0]           foods,
  output logic [num_foods-1:0]                   food_valid,
  output logic [num_players*score_len-1:0]       scores,
  output logic [num_players-1:0]                 eat,
  output logic                                   busy
);

  localparam int KW    = (max_len > 1) ? $clog2(max_len) : 1;
  localparam int FW    = (num_foods > 1) ? $clog2(num_foods) : 1;
  localparam int CELLS = width * height;
  localparam logic [KW-1:0]        K_LAST    = KW'(max_len - 1);
  localparam logic [KW-1:0]        K_ONE     = KW'(1);
  localparam logic [score_len-1:0] SCORE_MAX = {score_len{1'b1}};
  localparam logic [score_len-1:0] SCORE_ONE = score_len'(1);

  typedef enum logic [1:0] {S_IDLE, S_GEN, S_SCAN, S_COMMIT} state_t;

  state_t                           r_state;
  state_t                           w_next;
  logic [15:0]                      r_lfsr;
  logic [15:0]                      w_lfsr_next;
  logic [num_len-1:0]               r_cand;
  logic [num_len-1:0]               w_cand;
  logic                             w_cand_ok;
  logic [KW-1:0]                    r_k;
  logic [num_foods*num_len-1:0]     r_foods;
  logic [num_foods-1:0]             r_food_valid;
  logic [num_players*score_len-1:0] r_scores;
  logic [num_players-1:0]           r_eat;
  logic [num_foods-1:0]             w_hit_slot;
  logic [num_players-1:0]           w_credit;
  logic                             w_reject;
  logic                             w_any_free;
  logic [FW-1:0]                    w_free_idx;

  // Galois form of x^16+x^14+x^13+x^11+1, right-shifting.
  assign w_lfsr_next = {1'b0, r_lfsr[15:1]} ^ (r_lfsr[0] ? 16'hB400 : 16'h0000);
  assign w_cand      = r_lfsr[num_len-1:0];
  assign w_cand_ok   = (int'(w_cand) < CELLS);

  // A slot is credited to the lowest-index player whose head sits on it.
  always_comb begin
    w_hit_slot = '0;
    w_credit   = '0;
    for (int f = 0; f < num_foods; f++) begin
      for (int p = 0; p < num_players; p++) begin
        if (r_food_valid[f] && !w_hit_slot[f] &&
            (heads[p*num_len +: num_len] == r_foods[f*num_len +: num_len])) begin
          w_hit_slot[f] = 1'b1;
          w_credit[p]   = 1'b1;
        end
      end
    end
  end

  // Candidate collides with live segment k of any snake, any head or any live food.
  always_comb begin
    w_reject = 1'b0;
    for (int p = 0; p < num_players; p++) begin
      if ((int'(r_k) < int'(lens[p*score_len +: score_len])) &&
          (snakes[(p*max_len + int'(r_k))*num_len +: num_len] == r_cand)) begin
        w_reject = 1'b1;
      end
      if (heads[p*num_len +: num_len] == r_cand) begin
        w_reject = 1'b1;
      end
    end
    for (int f = 0; f < num_foods; f++) begin
      if (r_food_valid[f] && (r_foods[f*num_len +: num_len] == r_cand)) begin
        w_reject = 1'b1;
      end
    end
  end

  always_comb begin
    w_any_free = 1'b0;
    w_free_idx = '0;
    for (int f = num_foods - 1; f >= 0; f--) begin
      if (!r_food_valid[f]) begin
        w_any_free = 1'b1;
        w_free_idx = FW'(f);
      end
    end
  end

  // A tick means the board changed under the scan, so every refill state restarts in GEN.
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: begin
        if (!(&r_food_valid)) w_next = S_GEN;
        else                  w_next = S_IDLE;
      end
      S_GEN: begin
        if (tick)           w_next = S_GEN;
        else if (w_cand_ok) w_next = S_SCAN;
        else                w_next = S_GEN;
      end
      S_SCAN: begin
        if (tick || w_reject)  w_next = S_GEN;
        else if (r_k == K_LAST) w_next = S_COMMIT;
        else                   w_next = S_SCAN;
      end
      S_COMMIT: begin
        if (tick) w_next = S_GEN;
        else      w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_lfsr  <= lfsr_seed;
      r_cand  <= '0;
      r_k     <= '0;
    end else begin
      r_state <= w_next;
      r_lfsr  <= w_lfsr_next;
      if (r_state == S_GEN) begin
        r_cand <= w_cand;
        r_k    <= '0;
      end else if (r_state == S_SCAN) begin
        r_k <= r_k + K_ONE;
      end
    end
  end

  // Eat and commit never share an edge: a tick suppresses the commit.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_foods      <= '0;
      r_food_valid <= '0;
      r_scores     <= '0;
      r_eat        <= '0;
    end else begin
      r_eat <= tick ? w_credit : '0;
      if (tick) begin
        r_food_valid <= r_food_valid & ~w_hit_slot;
        for (int p = 0; p < num_players; p++) begin
          if (w_credit[p] && (r_scores[p*score_len +: score_len] != SCORE_MAX)) begin
            r_scores[p*score_len +: score_len] <= r_scores[p*score_len +: score_len] + SCORE_ONE;
          end
        end
      end else if ((r_state == S_COMMIT) && w_any_free) begin
        r_foods[w_free_idx*num_len +: num_len] <= r_cand;
        r_food_valid[w_free_idx]               <= 1'b1;
      end
    end
  end

  assign foods      = r_foods;
  assign food_valid = r_food_valid;
  assign scores     = r_scores;
  assign eat        = r_eat;
  assign busy       = (r_state != S_IDLE);

endmodule

// File: tb/tb_food_spawner.sv
// Directed bench for food_spawner: a default-size instance plus a 2x2-board instance.
module tb_food_spawner;

  localparam int NP = 2;
  localparam int NF = 2;
  localparam int ML = 16;
  localparam int NL = 10;
  localparam int SL = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                  rst, tick;
  logic [NP*ML*NL-1:0]   snakes;
  logic [NP*SL-1:0]      lens;
  logic [NP*NL-1:0]      heads;
  logic [NF*NL-1:0]      foods;
  logic [NF-1:0]         food_valid;
  logic [NP*SL-1:0]      scores;
  logic [NP-1:0]         eat;
  logic                  busy;

  logic                  rst_s, tick_s;
  logic [11:0]           snakes_s;
  logic [3:0]            lens_s;
  logic [2:0]            heads_s;
  logic [2:0]            foods_s;
  logic [0:0]            food_valid_s;
  logic [3:0]            scores_s;
  logic [0:0]            eat_s;
  logic                  busy_s;

  int n_checks = 0;
  int n_fail   = 0;

  food_spawner dut (
    .clk(clk), .rst(rst), .tick(tick), .snakes(snakes), .lens(lens), .heads(heads),
    .foods(foods), .food_valid(food_valid), .scores(scores), .eat(eat), .busy(busy)
  );

  food_spawner #(
    .num_players(1), .num_foods(1), .max_len(4), .num_len(3), .score_len(4),
    .width(2), .height(2), .lfsr_seed(16'hACE1)
  ) dut_s (
    .clk(clk), .rst(rst_s), .tick(tick_s), .snakes(snakes_s), .lens(lens_s), .heads(heads_s),
    .foods(foods_s), .food_valid(food_valid_s), .scores(scores_s), .eat(eat_s), .busy(busy_s)
  );

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic wait_full(input int budget, output int cyc);
    cyc = 0;
    while ((food_valid !== 2'b11) && (cyc < budget)) begin
      @(negedge clk);
      cyc++;
    end
  endtask

  task automatic pulse_tick();
    tick = 1'b1;
    @(negedge clk);
    tick = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; tick = 1'b0; snakes = '0; lens = '0; heads = '0;
    rst_s = 1'b1; tick_s = 1'b0; snakes_s = '0; lens_s = '0; heads_s = '0;
    repeat (3) @(negedge clk);
    n_checks++; if (food_valid !== 2'b00) begin n_fail++; $display("FAIL reset_valid: got %b expected 00", food_valid); end
    n_checks++; if (foods !== 20'd0) begin n_fail++; $display("FAIL reset_foods: got %h expected 0", foods); end
    n_checks++; if (scores !== 8'd0) begin n_fail++; $display("FAIL reset_scores: got %h expected 0", scores); end
    n_checks++; if (eat !== 2'b00) begin n_fail++; $display("FAIL reset_eat: got %b expected 00", eat); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b expected 0", busy); end
  endtask

  task automatic test_fill();
    int cyc;
    logic saw_out_of_order;
    heads = {10'd6, 10'd5};
    rst = 1'b0;
    cyc = 0;
    saw_out_of_order = 1'b0;
    while ((food_valid !== 2'b11) && (cyc < 1000)) begin
      @(negedge clk);
      cyc++;
      if (food_valid === 2'b10) saw_out_of_order = 1'b1;
    end
    n_checks++; if (food_valid !== 2'b11) begin n_fail++; $display("FAIL fill_timeout: valid %b expected 11", food_valid); end
    n_checks++; if (cyc < 38) begin n_fail++; $display("FAIL fill_latency: %0d cycles, expected at least 38", cyc); end
    n_checks++; if (saw_out_of_order !== 1'b0) begin n_fail++; $display("FAIL fill_order: slot 1 filled before slot 0"); end
    n_checks++; if (foods[9:0] === foods[19:10]) begin n_fail++; $display("FAIL fill_distinct: both %0d", foods[9:0]); end
    n_checks++; if ((foods[9:0] >= 10'd768) || (foods[19:10] >= 10'd768)) begin n_fail++; $display("FAIL fill_range: %0d %0d, expected < 768", foods[9:0], foods[19:10]); end
    n_checks++; if ((foods[9:0] inside {10'd5, 10'd6}) || (foods[19:10] inside {10'd5, 10'd6})) begin n_fail++; $display("FAIL fill_head: %0d %0d on a head", foods[9:0], foods[19:10]); end
    n_checks++; if (scores !== 8'd0) begin n_fail++; $display("FAIL fill_scores: got %h expected 0", scores); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL fill_idle: busy %b expected 0", busy); end
  endtask

  task automatic test_eat();
    logic [NL-1:0] f0, f1;
    int cyc;
    f0 = foods[9:0];
    f1 = foods[19:10];
    heads[9:0] = f0;
    pulse_tick();
    n_checks++; if (eat !== 2'b01) begin n_fail++; $display("FAIL eat_pulse: got %b expected 01", eat); end
    n_checks++; if (scores !== 8'h01) begin n_fail++; $display("FAIL eat_score: got %h expected 01", scores); end
    n_checks++; if (food_valid !== 2'b10) begin n_fail++; $display("FAIL eat_free: got %b expected 10", food_valid); end
    n_checks++; if (foods[19:10] !== f1) begin n_fail++; $display("FAIL eat_other: got %0d expected %0d", foods[19:10], f1); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL eat_preedge: busy %b expected 0", busy); end
    @(negedge clk);
    n_checks++; if (eat !== 2'b00) begin n_fail++; $display("FAIL eat_oneshot: got %b expected 00", eat); end
    n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL eat_refill_start: busy %b expected 1", busy); end
    wait_full(1000, cyc);
    n_checks++; if (food_valid !== 2'b11) begin n_fail++; $display("FAIL eat_refill_timeout: valid %b expected 11", food_valid); end
    n_checks++; if ((foods[9:0] === f0) || (foods[9:0] === foods[19:10]) || (foods[9:0] >= 10'd768)) begin n_fail++; $display("FAIL eat_refill_pos: got %0d, must differ from %0d and %0d", foods[9:0], f0, foods[19:10]); end
  endtask

  task automatic test_shared_hit();
    logic [NL-1:0] f1;
    int cyc;
    f1 = foods[19:10];
    heads = {f1, f1};
    pulse_tick();
    n_checks++; if (eat !== 2'b01) begin n_fail++; $display("FAIL shared_eat: got %b expected 01", eat); end
    n_checks++; if (scores !== 8'h02) begin n_fail++; $display("FAIL shared_score: got %h expected 02", scores); end
    n_checks++; if (food_valid !== 2'b01) begin n_fail++; $display("FAIL shared_free: got %b expected 01", food_valid); end
    wait_full(1000, cyc);
    n_checks++; if ((food_valid !== 2'b11) || (foods[19:10] === f1)) begin n_fail++; $display("FAIL shared_refill: valid %b pos %0d old %0d", food_valid, foods[19:10], f1); end
  endtask

  task automatic test_saturation();
    logic [SL-1:0] e;
    int cyc;
    e = 4'd2;
    for (int n = 0; n < 14; n++) begin
      heads[9:0] = foods[9:0];
      pulse_tick();
      e = (e == 4'd15) ? 4'd15 : e + 4'd1;
      n_checks++; if (eat !== 2'b01) begin n_fail++; $display("FAIL sat_eat: round %0d got %b expected 01", n, eat); end
      n_checks++; if (scores !== {4'd0, e}) begin n_fail++; $display("FAIL sat_score: round %0d got %h expected %h", n, scores, {4'd0, e}); end
      wait_full(1000, cyc);
    end
    n_checks++; if (food_valid !== 2'b11) begin n_fail++; $display("FAIL sat_refill: valid %b expected 11", food_valid); end
  endtask

  task automatic test_tick_abort();
    int cyc;
    logic [NL-1:0] nh;
    heads[9:0] = foods[9:0];
    pulse_tick();
    cyc = 0;
    while ((busy !== 1'b1) && (cyc < 50)) begin
      @(negedge clk);
      cyc++;
    end
    n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL abort_busy: busy %b expected 1", busy); end
    repeat (6) @(negedge clk);
    nh = (foods[19:10] == 10'd700) ? 10'd701 : 10'd700;
    heads[9:0] = nh;
    lens[3:0] = 4'd15;
    for (int i = 0; i < ML; i++) snakes[i*NL +: NL] = NL'(300 + i);
    pulse_tick();
    n_checks++; if (eat !== 2'b00) begin n_fail++; $display("FAIL abort_eat: got %b expected 00", eat); end
    for (int i = 0; i < 18; i++) begin
      n_checks++; if (food_valid[0] !== 1'b0) begin n_fail++; $display("FAIL abort_no_commit: cycle %0d valid %b expected 0", i, food_valid[0]); end
      @(negedge clk);
    end
    wait_full(1000, cyc);
    n_checks++; if (food_valid !== 2'b11) begin n_fail++; $display("FAIL abort_refill: valid %b expected 11", food_valid); end
    n_checks++; if (((foods[9:0] >= 10'd300) && (foods[9:0] <= 10'd314)) || (foods[9:0] === nh) || (foods[9:0] === foods[19:10])) begin n_fail++; $display("FAIL abort_body: food %0d lands on body, head %0d or other food", foods[9:0], nh); end
  endtask

  task automatic test_small_board();
    int cyc;
    logic stuck_valid, stuck_idle;
    snakes_s = {3'd3, 3'd2, 3'd1, 3'd0};
    lens_s = 4'd3;
    heads_s = 3'd2;
    rst_s = 1'b0;
    cyc = 0;
    while ((food_valid_s !== 1'b1) && (cyc < 3000)) begin @(negedge clk); cyc++; end
    n_checks++; if ((food_valid_s !== 1'b1) || (foods_s !== 3'd3)) begin n_fail++; $display("FAIL small_only_free: valid %b pos %0d expected 1 and 3", food_valid_s, foods_s); end
    heads_s = 3'd3;
    tick_s = 1'b1;
    @(negedge clk);
    tick_s = 1'b0;
    n_checks++; if ((eat_s !== 1'b1) || (scores_s !== 4'd1) || (food_valid_s !== 1'b0)) begin n_fail++; $display("FAIL small_eat: eat %b score %0d valid %b expected 1 1 0", eat_s, scores_s, food_valid_s); end
    snakes_s = {3'd1, 3'd3, 3'd2, 3'd1};
    lens_s = 4'd15;
    cyc = 0;
    while ((food_valid_s !== 1'b1) && (cyc < 3000)) begin @(negedge clk); cyc++; end
    n_checks++; if ((food_valid_s !== 1'b1) || (foods_s !== 3'd0)) begin n_fail++; $display("FAIL small_long_len: valid %b pos %0d expected 1 and 0", food_valid_s, foods_s); end
    heads_s = 3'd0;
    tick_s = 1'b1;
    @(negedge clk);
    tick_s = 1'b0;
    n_checks++; if (scores_s !== 4'd2) begin n_fail++; $display("FAIL small_score2: got %0d expected 2", scores_s); end
    stuck_valid = 1'b0;
    stuck_idle = 1'b0;
    repeat (300) begin
      @(negedge clk);
      if (food_valid_s !== 1'b0) stuck_valid = 1'b1;
      if (busy_s !== 1'b1) stuck_idle = 1'b1;
    end
    n_checks++; if (stuck_valid !== 1'b0) begin n_fail++; $display("FAIL full_board_commit: food committed on a full board"); end
    n_checks++; if (stuck_idle !== 1'b0) begin n_fail++; $display("FAIL full_board_busy: busy dropped on a full board"); end
    #2 rst_s = 1'b1;
    #1;
    n_checks++; if ((busy_s !== 1'b0) || (scores_s !== 4'd0) || (food_valid_s !== 1'b0)) begin n_fail++; $display("FAIL async_reset: busy %b score %0d valid %b expected 0 0 0", busy_s, scores_s, food_valid_s); end
    @(negedge clk);
    rst_s = 1'b0;
  endtask

  initial begin
    test_reset();
    test_fill();
    test_eat();
    test_shared_hit();
    test_saturation();
    test_tick_abort();
    test_small_board();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
